// File: rtl/wb_port_arbiter_if.sv
// Bundles the writeback, MDU handshake, register-file and hazard-query signals
// of the writeback port arbiter into a single interface.
interface wb_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            RegWriteW;
  logic [4:0]      rdW;
  logic [XLEN-1:0] ResultW;
  logic            mdu_valid;
  logic            mdu_ready;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic            rs1_pending;
  logic            rs2_pending;
  logic            stall_req;

  modport master (
    output RegWriteW, rdW, ResultW, mdu_valid, mdu_rd, mdu_data, rs1_q, rs2_q,
    input  mdu_ready, rf_we, rf_rd, rf_wd, rs1_pending, rs2_pending, stall_req
  );

  modport slave (
    input  RegWriteW, rdW, ResultW, mdu_valid, mdu_rd, mdu_data, rs1_q, rs2_q,
    output mdu_ready, rf_we, rf_rd, rf_wd, rs1_pending, rs2_pending, stall_req
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline writeback stage (absolute
// priority) and a small FIFO of MDU results that drain into otherwise idle slots.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  wb_port_arbiter_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, STALL} state_t;

  state_t          state, stateNext;
  logic [WW-1:0]   waitCnt, waitCntNext;
  logic [4:0]      rdMem   [DEPTH];
  logic [XLEN-1:0] dataMem [DEPTH];
  logic [DEPTH-1:0] validBits, occBits;
  logic [PW-1:0]   headPtr, tailPtr;
  logic [CW-1:0]   count, countNext;

  logic pipeWr, headOcc, headValid, pop, blocked, ready, accept, push;
  logic rs1Hit, rs2Hit;

  assign pipeWr    = bus.RegWriteW & (bus.rdW != 5'd0);
  assign headOcc   = (count != '0);
  assign headValid = headOcc & validBits[headPtr];
  // A squashed head leaves silently even while the pipeline owns the port.
  assign pop       = headOcc & (~validBits[headPtr] | ~pipeWr);
  assign blocked   = headValid & pipeWr;
  assign ready     = (count < CW'(DEPTH));
  assign accept    = bus.mdu_valid & ready;
  assign push      = accept & (bus.mdu_rd != 5'd0);

  assign bus.mdu_ready = ready;
  assign bus.stall_req = (state == STALL);

  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_rd = 5'd0;
    bus.rf_wd = '0;
    if (pipeWr) begin
      bus.rf_we = 1'b1;
      bus.rf_rd = bus.rdW;
      bus.rf_wd = bus.ResultW;
    end else if (headValid) begin
      bus.rf_we = 1'b1;
      bus.rf_rd = rdMem[headPtr];
      bus.rf_wd = dataMem[headPtr];
    end
  end

  always_comb begin
    rs1Hit = 1'b0;
    rs2Hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occBits[i] && validBits[i] && rdMem[i] == bus.rs1_q) rs1Hit = 1'b1;
      if (occBits[i] && validBits[i] && rdMem[i] == bus.rs2_q) rs2Hit = 1'b1;
    end
  end

  assign bus.rs1_pending = rs1Hit & (bus.rs1_q != 5'd0);
  assign bus.rs2_pending = rs2Hit & (bus.rs2_q != 5'd0);

  always_comb begin
    countNext = count;
    if (push && !pop)      countNext = count + CW'(1);
    else if (!push && pop) countNext = count - CW'(1);
  end

  // Payload storage needs no reset; occupancy and valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      rdMem[tailPtr]   <= bus.mdu_rd;
      dataMem[tailPtr] <= bus.mdu_data;
    end
  end

  // Queue bookkeeping; the tail slot is never occupied when pushed, so the squash
  // loop and the push never touch the same valid bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      count     <= '0;
      validBits <= '0;
      occBits   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pipeWr && occBits[i] && rdMem[i] == bus.rdW) validBits[i] <= 1'b0;
      end
      if (pop) begin
        occBits[headPtr]   <= 1'b0;
        validBits[headPtr] <= 1'b0;
        headPtr            <= headPtr + PW'(1);
      end
      if (push) begin
        occBits[tailPtr]   <= 1'b1;
        validBits[tailPtr] <= 1'b1;
        tailPtr            <= tailPtr + PW'(1);
      end
      count <= countNext;
    end
  end

  // Starvation tracking state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    case (state)
      IDLE: begin
        waitCntNext = '0;
        if (push) stateNext = WAIT;
      end
      WAIT: begin
        if (pop) begin
          waitCntNext = '0;
          if (countNext == '0) stateNext = IDLE;
        end else if (blocked) begin
          waitCntNext = waitCnt + WW'(1);
          if (waitCnt + WW'(1) >= WW'(STARVE_LIMIT)) stateNext = STALL;
        end
      end
      STALL: begin
        if (pop) begin
          waitCntNext = '0;
          stateNext   = (countNext == '0) ? IDLE : WAIT;
        end
      end
      default: begin
        stateNext   = IDLE;
        waitCntNext = '0;
      end
    endcase
  end
endmodule
